accumulator_feeder: RTL

ACCUMULATOR_FEEDER -- requirements
Module: accumulator_feeder

---
 rtl/accumulator_feeder_pkg.sv | 22 ++
 rtl/accumulator_feeder_buffer.sv | 35 +++
 rtl/accumulator_feeder.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/accumulator_feeder_pkg.sv
// Shared definitions for the accumulator feeder.
//   feeder_state_t : run-control FSM states
//   SETTLE_CYCLES  : idle cycles between the last word and the result capture
//   idx_width()    : width of a buffer index for a given depth (minimum 1 bit)
package accumulator_feeder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    GAP,
    SETTLE,
    READ,
    DONE
  } feeder_state_t;

  localparam int unsigned SETTLE_CYCLES = 2;

  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/accumulator_feeder_buffer.sv
// feeder_buffer: word storage for the accumulator feeder.
// One synchronous write port, one combinational read port addressed by index.
// Contents are not reset.
//   clk     : clock, rising edge
//   wr_en   : write wr_data to wr_addr at the next edge
//   wr_addr : write address
//   wr_data : write word
//   rd_addr : read address
//   rd_data : word stored at rd_addr (combinational)
module feeder_buffer
  import accumulator_feeder_pkg::*;
#(
  parameter int unsigned Word_Length = 8,
  parameter int unsigned Depth       = 4,
  parameter int unsigned IDX_W       = idx_width(Depth)
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic [IDX_W-1:0]       wr_addr,
  input  logic [Word_Length-1:0] wr_data,
  input  logic [IDX_W-1:0]       rd_addr,
  output logic [Word_Length-1:0] rd_data
);

  logic [Word_Length-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/accumulator_feeder.sv
// accumulator_feeder: buffers up to Depth words, then on Start streams them
// one at a time into an external accumulator (enable strobe with a re-arm
// gap after each word), waits for the accumulator to settle, strobes Read to
// capture the result and pulses Done.
//   clk         : clock, rising edge
//   reset       : synchronous, active-low
//   Load        : write Load_Data into the buffer (IDLE only, ignored when Full)
//   Load_Data   : word to buffer
//   Start       : begin a feed run (IDLE only)
//   Data_Output : word presented to the accumulator, 0 in IDLE
//   enable      : one-cycle add strobe per word
//   Read        : one-cycle result-capture strobe
//   Busy        : high in every state except IDLE
//   Done        : one-cycle pulse at run end
//   Full        : buffer holds Depth words
//   Count       : words held in the buffer
// Build option FEEDER_REPEAT_EN: DONE keeps Count (and the buffer) so a later
// Start replays the same words; otherwise Count clears in DONE.
module accumulator_feeder
  import accumulator_feeder_pkg::*;
#(
  parameter int unsigned Word_Length = 8,
  parameter int unsigned Depth       = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         Load,
  input  logic [Word_Length-1:0]       Load_Data,
  input  logic                         Start,
  output logic [Word_Length-1:0]       Data_Output,
  output logic                         enable,
  output logic                         Read,
  output logic                         Busy,
  output logic                         Done,
  output logic                         Full,
  output logic [$clog2(Depth+1)-1:0]   Count
);

  localparam int unsigned CNT_W = $clog2(Depth + 1);
  localparam int unsigned IDX_W = idx_width(Depth);

  feeder_state_t          state, state_n;
  logic [IDX_W-1:0]       index, index_n;
  logic [CNT_W-1:0]       count, count_n;
  logic [1:0]             settle_cnt, settle_n;
  logic                   wr_en;
  logic                   full;
  logic                   last_word;
  logic [Word_Length-1:0] rd_data;

  feeder_buffer #(
    .Word_Length (Word_Length),
    .Depth       (Depth),
    .IDX_W       (IDX_W)
  ) u_buffer (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (IDX_W'(count)),
    .wr_data (Load_Data),
    .rd_addr (index),
    .rd_data (rd_data)
  );

  assign full      = (count == CNT_W'(Depth));
  assign last_word = ((CNT_W'(index) + CNT_W'(1)) == count);
  assign Full      = full;
  assign Count     = count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      index      <= '0;
      count      <= '0;
      settle_cnt <= '0;
    end else begin
      state      <= state_n;
      index      <= index_n;
      count      <= count_n;
      settle_cnt <= settle_n;
    end
  end

  always_comb begin
    state_n     = state;
    index_n     = index;
    count_n     = count;
    settle_n    = settle_cnt;
    wr_en       = 1'b0;
    Data_Output = '0;
    enable      = 1'b0;
    Read        = 1'b0;
    Busy        = 1'b1;
    Done        = 1'b0;

    unique case (state)
      IDLE: begin
        Busy = 1'b0;
        if (Load && !full) begin
          wr_en   = 1'b1;
          count_n = count + CNT_W'(1);
        end
        // Start looks at the post-load count so a simultaneous Load joins the run.
        if (Start) begin
          index_n = '0;
          state_n = (count_n != '0) ? DRIVE : DONE;
        end
      end
      DRIVE: begin
        enable      = 1'b1;
        Data_Output = rd_data;
        state_n     = GAP;
      end
      GAP: begin
        Data_Output = rd_data;
        if (last_word) begin
          settle_n = '0;
          state_n  = SETTLE;
        end else begin
          index_n = index + IDX_W'(1);
          state_n = DRIVE;
        end
      end
      SETTLE: begin
        if (settle_cnt == 2'(SETTLE_CYCLES - 1)) begin
          state_n = READ;
        end else begin
          settle_n = settle_cnt + 2'd1;
        end
      end
      READ: begin
        Read    = 1'b1;
        state_n = DONE;
      end
      DONE: begin
        Done    = 1'b1;
`ifndef FEEDER_REPEAT_EN
        count_n = '0;
`endif
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
